// File: rtl/plotter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plotter_pkg
// Description : Shared types and default constants for the two-axis plotter
//               move sequencer and its tick timer.
// Revision    : 1.0 - initial release
// ============================================================================

package plotter_pkg;

  localparam int c_COUNT_W_DEFAULT       = 16;
  localparam int c_X_STEP_PERIOD_DEFAULT = 144337;
  localparam int c_Y_STEP_PERIOD_DEFAULT = 250000;
  localparam int c_PULSE_WIDTH_DEFAULT   = 1000;
  localparam int c_DIR_SETUP_DEFAULT     = 500;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_TICK  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/plotter_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : plotter_tick_timer
// Description : Free-running interpolation tick counter. Flags the first cycle
//               of each tick and the cycles in which step pulses are high.
// Revision    : 1.0 - initial release
// ============================================================================

module plotter_tick_timer
  import plotter_pkg::*;
#(
  parameter int STEP_PERIOD = c_Y_STEP_PERIOD_DEFAULT,
  parameter int PULSE_WIDTH = c_PULSE_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic not_reset,
  input  logic i_start,
  input  logic i_clear,
  output logic o_tick_start,
  output logic o_pulse_active
);

  localparam int                 c_CNT_W = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(STEP_PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_PULSE = c_CNT_W'(PULSE_WIDTH);

  logic               r_run;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
    end else if (r_run) begin
      r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // The sequencer registers step lines from these, so a tick's pulse appears
  // on the edge that ends the count==0 cycle.
  assign o_tick_start   = r_run && (r_cnt == '0);
  assign o_pulse_active = r_run && (r_cnt < c_PULSE);

endmodule

`default_nettype wire

// File: rtl/plotter_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : plotter_move_sequencer
// Description : Accepts straight-line move commands and drives X/Y step/dir
//               lines with Bresenham interpolation at a fixed tick rate.
// Revision    : 1.0 - initial release
// ============================================================================

module plotter_move_sequencer
  import plotter_pkg::*;
#(
  parameter int STEP_PERIOD = c_Y_STEP_PERIOD_DEFAULT,
  parameter int PULSE_WIDTH = c_PULSE_WIDTH_DEFAULT,
  parameter int DIR_SETUP   = c_DIR_SETUP_DEFAULT,
  parameter int COUNT_W     = c_COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               not_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COUNT_W-1:0] cmd_dx,
  input  logic [COUNT_W-1:0] cmd_dy,
  input  logic               cmd_dir_x,
  input  logic               cmd_dir_y,
  input  logic               abort,
  output logic               step_x,
  output logic               step_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int                   c_SETUP_W    = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [c_SETUP_W-1:0] c_SETUP_LAST = c_SETUP_W'(DIR_SETUP - 1);

  state_t               r_state,      w_state_nxt;
  logic [COUNT_W-1:0]   r_major,      w_major_nxt;
  logic [COUNT_W-1:0]   r_minor,      w_minor_nxt;
  logic [COUNT_W-1:0]   r_tick_cnt,   w_tick_cnt_nxt;
  logic [COUNT_W:0]     r_err,        w_err_nxt;
  logic [c_SETUP_W-1:0] r_setup_cnt,  w_setup_cnt_nxt;
  logic                 r_major_is_x, w_major_is_x_nxt;
  logic                 r_x_act,      w_x_act_nxt;
  logic                 r_y_act,      w_y_act_nxt;
  logic                 r_step_x,     w_step_x_nxt;
  logic                 r_step_y,     w_step_y_nxt;
  logic                 r_dir_x,      w_dir_x_nxt;
  logic                 r_dir_y,      w_dir_y_nxt;
  logic                 r_done,       w_done_nxt;
  logic                 r_aborted,    w_aborted_nxt;

  logic             w_timer_start;
  logic             w_timer_clear;
  logic             w_tick_start;
  logic             w_pulse_active;
  logic             w_cmd_x_major;
  logic             w_cmd_zero;
  logic [COUNT_W:0] w_err_sum;
  logic [COUNT_W:0] w_err_wrap;
  logic             w_minor_step;
  logic             w_x_now;
  logic             w_y_now;

  plotter_tick_timer #(
    .STEP_PERIOD (STEP_PERIOD),
    .PULSE_WIDTH (PULSE_WIDTH)
  ) u_tick_timer (
    .clk            (clk),
    .not_reset      (not_reset),
    .i_start        (w_timer_start),
    .i_clear        (w_timer_clear),
    .o_tick_start   (w_tick_start),
    .o_pulse_active (w_pulse_active)
  );

  assign w_cmd_x_major = (cmd_dx >= cmd_dy);
  assign w_cmd_zero    = (cmd_dx == '0) && (cmd_dy == '0);

  // One extra accumulator bit holds err+minor, which can reach 2*major-1.
  assign w_err_sum    = r_err + {1'b0, r_minor};
  assign w_err_wrap   = w_err_sum - {1'b0, r_major};
  assign w_minor_step = (w_err_sum >= {1'b0, r_major});
  assign w_x_now      = r_major_is_x | w_minor_step;
  assign w_y_now      = ~r_major_is_x | w_minor_step;

  always_comb begin
    w_state_nxt       = r_state;
    w_major_nxt       = r_major;
    w_minor_nxt       = r_minor;
    w_tick_cnt_nxt    = r_tick_cnt;
    w_err_nxt         = r_err;
    w_setup_cnt_nxt   = r_setup_cnt;
    w_major_is_x_nxt  = r_major_is_x;
    w_x_act_nxt       = r_x_act;
    w_y_act_nxt       = r_y_act;
    w_step_x_nxt      = 1'b0;
    w_step_y_nxt      = 1'b0;
    w_dir_x_nxt       = r_dir_x;
    w_dir_y_nxt       = r_dir_y;
    w_done_nxt        = 1'b0;
    w_aborted_nxt     = 1'b0;
    w_timer_start     = 1'b0;
    w_timer_clear     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_dir_x_nxt      = cmd_dir_x;
          w_dir_y_nxt      = cmd_dir_y;
          w_major_is_x_nxt = w_cmd_x_major;
          w_major_nxt      = w_cmd_x_major ? cmd_dx : cmd_dy;
          w_minor_nxt      = w_cmd_x_major ? cmd_dy : cmd_dx;
          w_err_nxt        = '0;
          w_tick_cnt_nxt   = '0;
          w_setup_cnt_nxt  = '0;
          w_x_act_nxt      = 1'b0;
          w_y_act_nxt      = 1'b0;
          if (w_cmd_zero) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        if (abort) begin
          w_state_nxt   = ST_IDLE;
          w_done_nxt    = 1'b1;
          w_aborted_nxt = 1'b1;
          w_timer_clear = 1'b1;
        end else if (r_setup_cnt == c_SETUP_LAST) begin
          // Timer's first count==0 cycle follows, so the first step edge
          // lands DIR_SETUP+1 cycles after the handshake.
          w_state_nxt   = ST_TICK;
          w_timer_start = 1'b1;
        end else begin
          w_setup_cnt_nxt = r_setup_cnt + 1'b1;
        end
      end

      ST_TICK: begin
        if (abort) begin
          w_state_nxt   = ST_IDLE;
          w_done_nxt    = 1'b1;
          w_aborted_nxt = 1'b1;
          w_timer_clear = 1'b1;
          w_x_act_nxt   = 1'b0;
          w_y_act_nxt   = 1'b0;
        end else if (w_tick_start) begin
          if (r_tick_cnt == r_major) begin
            w_state_nxt   = ST_IDLE;
            w_done_nxt    = 1'b1;
            w_timer_clear = 1'b1;
            w_x_act_nxt   = 1'b0;
            w_y_act_nxt   = 1'b0;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
            w_err_nxt      = w_minor_step ? w_err_wrap : w_err_sum;
            w_x_act_nxt    = w_x_now;
            w_y_act_nxt    = w_y_now;
            w_step_x_nxt   = w_x_now;
            w_step_y_nxt   = w_y_now;
          end
        end else begin
          w_step_x_nxt = r_x_act & w_pulse_active;
          w_step_y_nxt = r_y_act & w_pulse_active;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_timer_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_state      <= ST_IDLE;
      r_major      <= '0;
      r_minor      <= '0;
      r_tick_cnt   <= '0;
      r_err        <= '0;
      r_setup_cnt  <= '0;
      r_major_is_x <= 1'b0;
      r_x_act      <= 1'b0;
      r_y_act      <= 1'b0;
      r_step_x     <= 1'b0;
      r_step_y     <= 1'b0;
      r_dir_x      <= 1'b0;
      r_dir_y      <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_major      <= w_major_nxt;
      r_minor      <= w_minor_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_err        <= w_err_nxt;
      r_setup_cnt  <= w_setup_cnt_nxt;
      r_major_is_x <= w_major_is_x_nxt;
      r_x_act      <= w_x_act_nxt;
      r_y_act      <= w_y_act_nxt;
      r_step_x     <= w_step_x_nxt;
      r_step_y     <= w_step_y_nxt;
      r_dir_x      <= w_dir_x_nxt;
      r_dir_y      <= w_dir_y_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign step_x    = r_step_x;
  assign step_y    = r_step_y;
  assign dir_x     = r_dir_x;
  assign dir_y     = r_dir_y;
  assign done      = r_done;
  assign aborted   = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_plotter_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_plotter_move_sequencer
// Description : Directed self-checking bench for plotter_move_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_plotter_move_sequencer;

  localparam int SP = 10;
  localparam int PW = 2;
  localparam int DS = 3;
  localparam int CW = 16;
  localparam int T  = 10;

  logic          clk       = 1'b0;
  logic          not_reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_dx    = '0;
  logic [CW-1:0] cmd_dy    = '0;
  logic          cmd_dir_x = 1'b0;
  logic          cmd_dir_y = 1'b0;
  logic          abort     = 1'b0;
  logic          step_x;
  logic          step_y;
  logic          dir_x;
  logic          dir_y;
  logic          busy;
  logic          done;
  logic          aborted;

  always #5 clk = ~clk;

  plotter_move_sequencer #(
    .STEP_PERIOD (SP),
    .PULSE_WIDTH (PW),
    .DIR_SETUP   (DS),
    .COUNT_W     (CW)
  ) dut (
    .clk       (clk),
    .not_reset (not_reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dx    (cmd_dx),
    .cmd_dy    (cmd_dy),
    .cmd_dir_x (cmd_dir_x),
    .cmd_dir_y (cmd_dir_y),
    .abort     (abort),
    .step_x    (step_x),
    .step_y    (step_y),
    .dir_x     (dir_x),
    .dir_y     (dir_y),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  int n_checks  = 0;
  int n_pass    = 0;
  int n_fail    = 0;
  int nx        = 0;
  int ny        = 0;
  int ndone     = 0;
  int nabort    = 0;
  int bad_abort = 0;
  int x_fall    = 0;
  int done_rise = 0;
  int x_rise[8];
  int y_rise[8];

  // Pulse/event monitors: record edge times and counts of the DUT outputs.
  always @(posedge step_x) begin
    if (nx < 8) x_rise[nx] = int'($time);
    nx = nx + 1;
  end
  always @(posedge step_y) begin
    if (ny < 8) y_rise[ny] = int'($time);
    ny = ny + 1;
  end
  always @(negedge step_x) x_fall = int'($time);
  always @(posedge done) done_rise = int'($time);
  always @(posedge clk) begin
    if (done) begin
      ndone = ndone + 1;
      if (aborted) nabort = nabort + 1;
    end
  end
  always @(negedge clk) if (aborted && !done) bad_abort = bad_abort + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    nx = 0; ny = 0; ndone = 0; nabort = 0; x_fall = 0; done_rise = 0;
    for (int i = 0; i < 8; i++) begin
      x_rise[i] = 0;
      y_rise[i] = 0;
    end
  endtask

  // Called at a negedge; returns at the following negedge with valid dropped.
  task automatic send(input int dx, input int dy, input logic dxd, input logic dyd,
                      output int t_hs);
    chk("hs_ready", int'(cmd_ready), 1);
    cmd_dx    = CW'(dx);
    cmd_dy    = CW'(dy);
    cmd_dir_x = dxd;
    cmd_dir_y = dyd;
    cmd_valid = 1'b1;
    @(posedge clk);
    t_hs = int'($time);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int found);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
  endtask

  task automatic wait_nx(input int n, input int budget, output int found);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (nx >= n) begin
        found = 1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, f, c, b;

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({cmd_ready, busy, step_x, step_y, dir_x, dir_y, done, aborted}),
        int'(8'b1000_0000));
    not_reset = 1'b1;
    @(negedge clk);

    // dx=4, dy=2, X major
    clr_mon();
    send(4, 2, 1'b1, 1'b0, t);
    chk("A_dir", int'({dir_x, dir_y}), 2);
    chk("A_busy_ready", int'({busy, cmd_ready}), 2);
    wait_done(100, f);
    chk("A_done_seen", f, 1);
    chk("A_first_step_x", x_rise[0] - t, 4 * T);
    chk("A_nx", nx, 4);
    chk("A_ny", ny, 2);
    chk("A_x_spacing", x_rise[3] - x_rise[0], 3 * SP * T);
    chk("A_y_tick2", y_rise[0] - x_rise[0], 1 * SP * T);
    chk("A_y_tick4", y_rise[1] - x_rise[0], 3 * SP * T);
    chk("A_pulse_width", x_fall - x_rise[3], PW * T);
    chk("A_done_time", done_rise - x_rise[0], 4 * SP * T);
    chk("A_done_flags", int'({busy, aborted}), 0);
    @(negedge clk);
    chk("A_done_count", ndone, 1);
    chk("A_done_low", int'(done), 0);

    // dx=dy=3, both axes every tick
    clr_mon();
    send(3, 3, 1'b0, 1'b1, t);
    chk("B_dir", int'({dir_x, dir_y}), 1);
    wait_done(100, f);
    chk("B_done_seen", f, 1);
    chk("B_nx", nx, 3);
    chk("B_ny", ny, 3);
    c = 0;
    for (int k = 0; k < 3; k++) if (x_rise[k] != 0 && x_rise[k] == y_rise[k]) c++;
    chk("B_coincident", c, 3);
    @(negedge clk);
    chk("B_done_count", ndone, 1);

    // zero-length move
    clr_mon();
    send(0, 0, 1'b1, 1'b1, t);
    chk("C_done_busy", int'({done, aborted, busy}), 4);
    chk("C_dir", int'({dir_x, dir_y}), 3);
    chk("C_done_time", done_rise - t, 0);
    b = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b = b | int'(busy);
    end
    chk("C_busy_never", b, 0);
    chk("C_no_steps", nx + ny, 0);
    chk("C_done_count", ndone, 1);

    // dx=0, dy=5, then back-to-back command while done is high
    clr_mon();
    send(0, 5, 1'b0, 1'b0, t);
    wait_done(100, f);
    chk("D_done_seen", f, 1);
    chk("D_nx", nx, 0);
    chk("D_ny", ny, 5);
    chk("D_ready_with_done", int'(cmd_ready), 1);
    clr_mon();
    send(2, 1, 1'b1, 1'b1, t2);
    chk("D_b2b_accepted", int'({busy, dir_x, dir_y}), 7);
    wait_done(100, f);
    chk("D2_done_seen", f, 1);
    chk("D2_nx", nx, 2);
    chk("D2_ny", ny, 1);
    @(negedge clk);

    // abort during tick 2 of dx=6, dy=1
    clr_mon();
    send(6, 1, 1'b0, 1'b0, t);
    wait_nx(2, 100, f);
    chk("E_reached_tick2", nx, 2);
    chk("E_step_high", int'(step_x), 1);
    abort = 1'b1;
    @(negedge clk);
    chk("E_abort_outputs", int'({step_x, step_y, done, aborted, busy, cmd_ready}), 13);
    abort = 1'b0;
    @(negedge clk);
    chk("E_after_abort", int'({done, aborted}), 0);
    repeat (30) @(negedge clk);
    chk("E_nx", nx, 2);
    chk("E_ny", ny, 0);
    chk("E_abort_count", nabort, 1);

    // abort with handshake in IDLE is ignored; then reset mid-tick
    clr_mon();
    abort = 1'b1;
    send(5, 0, 1'b1, 1'b1, t);
    abort = 1'b0;
    chk("F_hs_with_abort", int'({busy, done}), 2);
    wait_nx(1, 100, f);
    chk("F_step_high", int'(step_x), 1);
    not_reset = 1'b0;
    #1;
    chk("F_reset_async", int'({step_x, step_y, cmd_ready, busy, dir_x, dir_y, done, aborted}),
        int'(8'b0010_0000));
    @(negedge clk);
    not_reset = 1'b1;
    repeat (60) @(negedge clk);
    chk("F_no_more_steps", nx, 1);
    chk("F_idle", int'({busy, cmd_ready}), 1);

    chk("aborted_without_done", bad_abort, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
